// File: rtl/hazard_ctrl_pkg.sv
// Shared types for hazard_ctrl: FSM encodings, forward-select codes and RAW-match helpers.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RSVD  = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic logic dst_hit(input logic rw, input logic [4:0] dst, input logic [4:0] src);
    return rw && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic raw_hit(input logic rw, input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
    return dst_hit(rw, dst, rs) || (uses_rt && dst_hit(rw, dst, rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of hazard_ctrl; master drives pipeline state, slave is the controller.
interface hazard_ctrl_if;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_uses_rt;
  logic [4:0] i_ex_dst;
  logic [4:0] i_mem_dst;
  logic [4:0] i_wb_dst;
  logic       i_ex_regwrite;
  logic       i_mem_regwrite;
  logic       i_wb_regwrite;
  logic       i_ex_memread;
  logic [4:0] i_ex_rs;
  logic [4:0] i_ex_rt;
  logic       i_jump;
  logic       i_branch_taken;
  logic       o_pc_write;
  logic       o_if_id_write;
  logic       o_hazard_to_id;
  logic       o_id_flush;
  logic       o_if_flush;
  logic       o_ex_flush;
  logic [1:0] o_fwd_a;
  logic [1:0] o_fwd_b;
  logic [1:0] o_state;
  logic [15:0] o_stall_cycles;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_dst, i_mem_dst, i_wb_dst,
           i_ex_regwrite, i_mem_regwrite, i_wb_regwrite, i_ex_memread,
           i_ex_rs, i_ex_rt, i_jump, i_branch_taken,
    input  o_pc_write, o_if_id_write, o_hazard_to_id, o_id_flush, o_if_flush,
           o_ex_flush, o_fwd_a, o_fwd_b, o_state, o_stall_cycles
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_dst, i_mem_dst, i_wb_dst,
           i_ex_regwrite, i_mem_regwrite, i_wb_regwrite, i_ex_memread,
           i_ex_rs, i_ex_rt, i_jump, i_branch_taken,
    output o_pc_write, o_if_id_write, o_hazard_to_id, o_id_flush, o_if_flush,
           o_ex_flush, o_fwd_a, o_fwd_b, o_state, o_stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding select; MEM result beats WB result, register file otherwise.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] mem_dst,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_dst,
  input  logic       wb_regwrite,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] sel(input logic [4:0] src);
    if (dst_hit(mem_regwrite, mem_dst, src)) return FWD_MEM;
    else if (dst_hit(wb_regwrite, wb_dst, src)) return FWD_WB;
    else return FWD_RF;
  endfunction

  assign fwd_a = sel(ex_rs);
  assign fwd_b = sel(ex_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall FSM, branch/jump flushes, saturating stall counter.
// Build option HAZARD_CTRL_FORWARD_EN: operand forwarding, so only load-use hazards stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  hazard_ctrl_if.slave hif
);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [1:0]  need_n;
  logic [1:0]  fwd_a_raw, fwd_b_raw;
  logic [15:0] stall_cycles;
  logic        raw_ex;
  logic        stall_req;
  logic        pc_write, if_id_write, hazard_to_id, id_flush, if_flush, ex_flush;
  logic [1:0]  fwd_a, fwd_b;

  assign raw_ex = raw_hit(hif.i_ex_regwrite, hif.i_ex_dst, hif.i_id_rs, hif.i_id_rt, hif.i_id_uses_rt);

`ifdef HAZARD_CTRL_FORWARD_EN
  assign need_n = (hif.i_ex_memread && raw_ex) ? 2'd1 : 2'd0;

  fwd_unit u_fwd (
    .mem_dst      (hif.i_mem_dst),
    .mem_regwrite (hif.i_mem_regwrite),
    .wb_dst       (hif.i_wb_dst),
    .wb_regwrite  (hif.i_wb_regwrite),
    .ex_rs        (hif.i_ex_rs),
    .ex_rt        (hif.i_ex_rt),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );
`else
  logic raw_mem, raw_wb;
  assign raw_mem = raw_hit(hif.i_mem_regwrite, hif.i_mem_dst, hif.i_id_rs, hif.i_id_rt, hif.i_id_uses_rt);
  assign raw_wb  = raw_hit(hif.i_wb_regwrite, hif.i_wb_dst, hif.i_id_rs, hif.i_id_rt, hif.i_id_uses_rt);
  assign need_n  = raw_ex ? 2'd3 : raw_mem ? 2'd2 : raw_wb ? 2'd1 : 2'd0;
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
`endif

  assign stall_req = (need_n != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_RUN;
      cnt          <= 2'd0;
      stall_cycles <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (hazard_to_id && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // The RUN cycle that detects the hazard is the first stall cycle, so a one-cycle stall never leaves RUN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (hif.i_branch_taken) begin
      state_n = ST_FLUSH;
      cnt_n   = 2'd0;
    end else begin
      case (state)
        ST_STALL: begin
          cnt_n   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
          state_n = (cnt <= 2'd1) ? ST_RUN : ST_STALL;
        end
        ST_FLUSH: state_n = ST_RUN;
        default: begin
          state_n = ST_RUN;
          if (stall_req) begin
            cnt_n   = need_n - 2'd1;
            state_n = (need_n > 2'd1) ? ST_STALL : ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    hazard_to_id = 1'b0;
    id_flush     = 1'b0;
    if_flush     = 1'b0;
    ex_flush     = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    if (i_rst_n) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (hif.i_branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end else begin
        case (state)
          ST_STALL: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            hazard_to_id = 1'b1;
          end
          ST_FLUSH: id_flush = 1'b1;
          default: begin
            if (stall_req) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              hazard_to_id = 1'b1;
            end else if (hif.i_jump) begin
              if_flush = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign hif.o_pc_write     = pc_write;
  assign hif.o_if_id_write  = if_id_write;
  assign hif.o_hazard_to_id = hazard_to_id;
  assign hif.o_id_flush     = id_flush;
  assign hif.o_if_flush     = if_flush;
  assign hif.o_ex_flush     = ex_flush;
  assign hif.o_fwd_a        = fwd_a;
  assign hif.o_fwd_b        = fwd_b;
  assign hif.o_state        = state;
  assign hif.o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table in RUN plus clocked stall/flush/reset sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hif     (hif)
  );

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       uses_rt;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       ex_rw, mem_rw, wb_rw, ex_mr;
    logic [4:0] ex_rs, ex_rt;
    logic       jump, br;
    logic [5:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  // ctl = {pc_write, if_id_write, hazard_to_id, id_flush, if_flush, ex_flush}
  localparam logic [5:0] CTL_IDLE  = 6'b110000;
  localparam logic [5:0] CTL_STALL = 6'b001000;
  localparam logic [5:0] CTL_BR    = 6'b110111;
  localparam logic [5:0] CTL_JMP   = 6'b110010;
  localparam logic [5:0] CTL_FLUSH = 6'b110100;
`ifdef HAZARD_CTRL_FORWARD_EN
  localparam logic [5:0] CTL_RAW = CTL_IDLE;
  localparam logic [1:0] F_MEM = 2'b10;
  localparam logic [1:0] F_WB  = 2'b01;
`else
  localparam logic [5:0] CTL_RAW = CTL_STALL;
  localparam logic [1:0] F_MEM = 2'b00;
  localparam logic [1:0] F_WB  = 2'b00;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int exp_sc = 0;
  vec_t tbl[$];
  vec_t v, lu, idle_vec;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t idle_v();
    vec_t r;
    r = '{default: '0};
    r.exp_ctl = CTL_IDLE;
    return r;
  endfunction

  task automatic drive(input vec_t d);
    hif.i_id_rs = d.id_rs;          hif.i_id_rt = d.id_rt;
    hif.i_id_uses_rt = d.uses_rt;   hif.i_ex_dst = d.ex_dst;
    hif.i_mem_dst = d.mem_dst;      hif.i_wb_dst = d.wb_dst;
    hif.i_ex_regwrite = d.ex_rw;    hif.i_mem_regwrite = d.mem_rw;
    hif.i_wb_regwrite = d.wb_rw;    hif.i_ex_memread = d.ex_mr;
    hif.i_ex_rs = d.ex_rs;          hif.i_ex_rt = d.ex_rt;
    hif.i_jump = d.jump;            hif.i_branch_taken = d.br;
  endtask

  function automatic logic [15:0] ctl();
    return {10'd0, hif.o_pc_write, hif.o_if_id_write, hif.o_hazard_to_id,
            hif.o_id_flush, hif.o_if_flush, hif.o_ex_flush};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_vec = idle_v();
    lu = idle_v(); lu.ex_dst = 5; lu.ex_rw = 1; lu.ex_mr = 1; lu.id_rs = 5; lu.exp_ctl = CTL_STALL;

    v = idle_v();                                                   tbl.push_back(v);
    v = idle_v(); v.ex_dst = 5; v.ex_rw = 1; v.id_rs = 5; v.exp_ctl = CTL_RAW; tbl.push_back(v);
    tbl.push_back(lu);
    v = idle_v(); v.ex_dst = 5; v.ex_rw = 1; v.id_rs = 1; v.id_rt = 5;        tbl.push_back(v);
    v.uses_rt = 1; v.exp_ctl = CTL_RAW;                                       tbl.push_back(v);
    v = idle_v(); v.ex_dst = 0; v.ex_rw = 1; v.ex_mr = 1;                     tbl.push_back(v);
    v = idle_v(); v.mem_dst = 9; v.mem_rw = 1; v.id_rs = 9; v.exp_ctl = CTL_RAW; tbl.push_back(v);
    v = idle_v(); v.wb_dst = 3; v.wb_rw = 1; v.id_rt = 3; v.uses_rt = 1; v.exp_ctl = CTL_RAW; tbl.push_back(v);
    v = idle_v(); v.ex_dst = 5; v.ex_mr = 1; v.id_rs = 5;                     tbl.push_back(v);
    v = idle_v(); v.jump = 1; v.exp_ctl = CTL_JMP;                            tbl.push_back(v);
    v = lu; v.jump = 1; v.exp_ctl = CTL_STALL;                                tbl.push_back(v);
    v = lu; v.br = 1; v.exp_ctl = CTL_BR;                                     tbl.push_back(v);
    v = idle_v(); v.mem_dst = 7; v.wb_dst = 7; v.mem_rw = 1; v.wb_rw = 1; v.ex_rs = 7; v.exp_fa = F_MEM; tbl.push_back(v);
    v.mem_rw = 0; v.exp_fa = F_WB;                                            tbl.push_back(v);
    v.mem_rw = 1; v.mem_dst = 0; v.wb_dst = 0; v.exp_fa = 2'b00;              tbl.push_back(v);
    v = idle_v(); v.mem_dst = 7; v.mem_rw = 1; v.ex_rt = 7; v.ex_rs = 3; v.exp_fb = F_MEM; tbl.push_back(v);
    v = idle_v(); v.wb_dst = 4; v.wb_rw = 1; v.mem_dst = 4; v.ex_rt = 4; v.exp_fb = F_WB;  tbl.push_back(v);

    // Reset: hazard inputs present, outputs must still show reset values.
    v = lu; v.mem_dst = 7; v.mem_rw = 1; v.ex_rs = 7; v.ex_rt = 7;
    drive(v);
    #1;
    chk("reset_ctl", ctl(), {10'd0, CTL_IDLE});
    chk("reset_state", {14'd0, hif.o_state}, 16'd0);
    chk("reset_sc", hif.o_stall_cycles, 16'd0);
    chk("reset_fwd", {12'd0, hif.o_fwd_a, hif.o_fwd_b}, 16'd0);
    drive(idle_vec);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl(), {10'd0, tbl[i].exp_ctl});
      chk($sformatf("vec%0d_fwd_a", i), {14'd0, hif.o_fwd_a}, {14'd0, tbl[i].exp_fa});
      chk($sformatf("vec%0d_fwd_b", i), {14'd0, hif.o_fwd_b}, {14'd0, tbl[i].exp_fb});
      drive(idle_vec);
    end
    chk("table_sc", hif.o_stall_cycles, 16'd0);

    // Basic stall length.
    @(negedge clk);
`ifdef HAZARD_CTRL_FORWARD_EN
    drive(lu);
    #1 chk("lu_first_haz", ctl(), {10'd0, CTL_STALL});
    step(); exp_sc++; drive(idle_vec); #1;
    chk("lu_done_state", {14'd0, hif.o_state}, 16'd0);
    chk("lu_done_ctl", ctl(), {10'd0, CTL_IDLE});
    chk("lu_sc", hif.o_stall_cycles, 16'd1);
`else
    v = idle_v(); v.ex_dst = 5; v.ex_rw = 1; v.id_rt = 5; v.uses_rt = 1;
    drive(v);
    #1 chk("n3_c1_ctl", ctl(), {10'd0, CTL_STALL});
    chk("n3_c1_state", {14'd0, hif.o_state}, 16'd0);
    step(); exp_sc++; drive(idle_vec); #1;
    chk("n3_c2_state", {14'd0, hif.o_state}, 16'd1);
    chk("n3_c2_ctl", ctl(), {10'd0, CTL_STALL});
    step(); exp_sc++;
    chk("n3_c3_ctl", ctl(), {10'd0, CTL_STALL});
    step(); exp_sc++;
    chk("n3_done_state", {14'd0, hif.o_state}, 16'd0);
    chk("n3_done_ctl", ctl(), {10'd0, CTL_IDLE});
    chk("n3_sc", hif.o_stall_cycles, 16'd3);
`endif

    // Branch inside a stall, then one FLUSH cycle with detection suppressed.
    @(negedge clk);
    drive(lu);
`ifndef HAZARD_CTRL_FORWARD_EN
    step(); exp_sc++; drive(idle_vec); #1;
    chk("br_pre_state", {14'd0, hif.o_state}, 16'd1);
`endif
    hif.i_branch_taken = 1'b1;
    #1 chk("br_ctl", ctl(), {10'd0, CTL_BR});
    step();
    drive(lu);
    #1 chk("flush_state", {14'd0, hif.o_state}, 16'd2);
    chk("flush_ctl", ctl(), {10'd0, CTL_FLUSH});
    step(); drive(idle_vec); #1;
    chk("post_flush_state", {14'd0, hif.o_state}, 16'd0);
    chk("post_flush_ctl", ctl(), {10'd0, CTL_IDLE});
    chk("post_flush_sc", hif.o_stall_cycles, exp_sc[15:0]);

    // Jump held in ID behind a load-use stall.
    @(negedge clk);
    v = lu; v.jump = 1;
    drive(v);
    #1 chk("jmp_stall_ctl", ctl(), {10'd0, CTL_STALL});
    v = idle_v(); v.jump = 1;
    step(); exp_sc++; drive(v); #1;
`ifndef HAZARD_CTRL_FORWARD_EN
    chk("jmp_s2_ctl", ctl(), {10'd0, CTL_STALL});
    step(); exp_sc++;
    chk("jmp_s3_ctl", ctl(), {10'd0, CTL_STALL});
    step(); exp_sc++;
`endif
    chk("jmp_release_ctl", ctl(), {10'd0, CTL_JMP});
    drive(idle_vec);
    step();
    chk("jmp_sc", hif.o_stall_cycles, exp_sc[15:0]);

    // Continuous hazard drives the counter into saturation.
    @(negedge clk);
    drive(lu);
    repeat (65534 - exp_sc) @(posedge clk);
    #1 chk("sat_fffe", hif.o_stall_cycles, 16'hFFFE);
    step(); chk("sat_ffff", hif.o_stall_cycles, 16'hFFFF);
    step(); chk("sat_hold1", hif.o_stall_cycles, 16'hFFFF);
    step(); chk("sat_hold2", hif.o_stall_cycles, 16'hFFFF);
    drive(idle_vec);
    repeat (3) step();
    chk("sat_idle_state", {14'd0, hif.o_state}, 16'd0);
    chk("sat_idle_sc", hif.o_stall_cycles, 16'hFFFF);

    // Reset asserted in the middle of a stall.
    @(negedge clk);
    drive(lu);
    step();
`ifndef HAZARD_CTRL_FORWARD_EN
    chk("rst_pre_state", {14'd0, hif.o_state}, 16'd1);
`endif
    v = lu; v.mem_dst = 7; v.mem_rw = 1; v.ex_rs = 7; v.ex_rt = 7;
    drive(v);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_state", {14'd0, hif.o_state}, 16'd0);
    chk("rst_mid_ctl", ctl(), {10'd0, CTL_IDLE});
    chk("rst_mid_sc", hif.o_stall_cycles, 16'd0);
    chk("rst_mid_fwd", {12'd0, hif.o_fwd_a, hif.o_fwd_b}, 16'd0);
    drive(idle_vec);
    #1 rst_n = 1'b1;
    step();
    chk("rst_after_state", {14'd0, hif.o_state}, 16'd0);
    chk("rst_after_ctl", ctl(), {10'd0, CTL_IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: i_clk input 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have inputs i_id_rs, i_id_rt (5 each), the source register fields of the instruction in ID, plus i_id_uses_rt (1), set when rt is read.
REQ-004 SHALL have inputs i_ex_dst, i_mem_dst, i_wb_dst (5 each), destination registers in EX/MEM/WB, with i_ex_regwrite, i_mem_regwrite, i_wb_regwrite and i_ex_memread (1 each).
REQ-005 SHALL have inputs i_ex_rs, i_ex_rt (5 each), the source registers of the instruction in EX, used for forwarding.
REQ-006 SHALL have inputs i_jump (1, jump decoded in ID) and i_branch_taken (1, branch resolved taken in MEM).
REQ-007 SHALL have outputs o_pc_write and o_if_id_write (1 each), both active-high enables.
REQ-008 SHALL have outputs o_hazard_to_id (1, bubble into ID/EX) and o_id_flush (1, squash ID/EX).
REQ-009 SHALL have outputs o_if_flush (1, squash IF/ID) and o_ex_flush (1, squash EX/MEM controls).
REQ-010 SHALL have outputs o_fwd_a, o_fwd_b (2 each), the ALU operand selects: 00 register file, 01 WB, 10 MEM.
REQ-011 SHALL have outputs o_state (2, FSM state) and o_stall_cycles (16, saturating stall counter).

Function
REQ-012 SHALL implement FSM states RUN=0, STALL=1, FLUSH=2, with encoding 3 unreachable and treated as RUN.
REQ-013 A RAW match SHALL require regwrite=1, dst!=0, and dst==i_id_rs or (i_id_uses_rt and dst==i_id_rt).
REQ-014 In RUN with a required stall count N>0, the block SHALL go to STALL, load the 2-bit counter with N-1, and assert the stall outputs in that same cycle.
REQ-015 The stall outputs SHALL be o_pc_write=0, o_if_id_write=0 and o_hazard_to_id=1, held for exactly N cycles in total.
REQ-016 In STALL, the block SHALL decrement the counter each cycle and return to RUN when the counter is 0; no new detection occurs while in STALL.
REQ-017 i_branch_taken=1 in any state SHALL assert o_if_flush, o_id_flush and o_ex_flush in that cycle.
REQ-018 i_branch_taken SHALL also clear the stall counter, deassert the stall outputs, and move the FSM to FLUSH.
REQ-019 FLUSH SHALL last exactly one cycle with detection suppressed and o_id_flush=1, then go to RUN.
REQ-020 i_jump=1 in RUN with no stall SHALL assert o_if_flush for one cycle; i_jump is ignored while a stall is asserted, because the jump is held in ID.
REQ-021 Priority SHALL be branch_taken > stall > jump.
REQ-022 The forwarding priority for o_fwd_a (i_ex_rs) SHALL be: MEM match gives 10, else WB match gives 01, else 00; a match requires regwrite=1 and dst!=0.
REQ-023 o_fwd_b SHALL follow the same rule as o_fwd_a using i_ex_rt.
REQ-024 o_stall_cycles SHALL increment on every cycle with o_hazard_to_id=1 and saturate at 16'hFFFF.
REQ-025 With no event, the outputs SHALL be o_pc_write=1, o_if_id_write=1, and all flush/bubble outputs 0.

Reset
REQ-026 Reset SHALL set the FSM to RUN, the counter to 0, and o_stall_cycles to 0.
REQ-027 During reset, the outputs SHALL be o_pc_write=1, o_if_id_write=1, all flush/bubble outputs 0, and o_fwd_a=o_fwd_b=00.
REQ-028 Reset asserted mid-STALL SHALL abort the stall immediately.

Configuration
REQ-029 With macro HAZARD_CTRL_FORWARD_EN defined, N SHALL be 1 only for a load-use case (i_ex_memread=1 with an EX RAW match), and 0 otherwise.
REQ-030 Without HAZARD_CTRL_FORWARD_EN, N SHALL be 3 for an EX match, else 2 for a MEM match, else 1 for a WB match (the RF is written at the same edge), and 0 otherwise.
REQ-031 Without HAZARD_CTRL_FORWARD_EN, o_fwd_a and o_fwd_b SHALL be tied to 00.

Structure
REQ-032 The shared package SHALL hold the state encodings and the forward-select constants (FWD_RF, FWD_WB, FWD_MEM).
REQ-033 Forwarding SHALL be a combinational sub-module fwd_unit, instantiated only under HAZARD_CTRL_FORWARD_EN.

Verification
REQ-034 Load-use, forwarding enabled: ex_memread=1, ex_dst=5, id_rs=5 -> 1 stall cycle, o_stall_cycles=1.
REQ-035 Forwarding disabled: ex_dst=5 with regwrite, id_rt=5, uses_rt=1 -> 3 stall cycles, then RUN.
REQ-036 Forwarding: mem_dst=wb_dst=7, both regwrite, ex_rs=7 -> o_fwd_a=10; with mem_regwrite=0 -> 01; with dst=0 -> 00.
REQ-037 Branch during the 2nd of 3 stall cycles -> all flushes 1 that cycle, one FLUSH cycle, then RUN with stall outputs released.
REQ-038 Jump coincident with load-use -> stall only, with o_if_flush=0; the next cycle in RUN -> o_if_flush=1.
REQ-039 Counter preloaded near saturation via repeated stalls -> o_stall_cycles holds at 16'hFFFF; reset mid-STALL -> RUN, all outputs at reset values.
